key_direction_filter: RTL and testbench
=======================================

KEY_DIRECTION_FILTER -- requirements
Module: key_direction_filter

Interface
REQ-001 The module SHALL have no parameters; all constants SHALL come from key_pkg.
REQ-002 Clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 report_valid  input  1  one-cycle pulse; the keycode_0..keycode_3 inputs hold a new USB HID report.
REQ-005 keycode_0, keycode_1, keycode_2, keycode_3  input  8 each  report key slots; 8'h00 means an empty slot.
REQ-006 frame_tick  input  1  one-cycle pulse at each frame boundary.
REQ-007 keycode_out  output  8  filtered movement keycode for the ball stage; one of 8'h1A/8'h04/8'h16/8'h07, or 8'h00.
REQ-008 key_new  output  1  one-cycle pulse when keycode_out changes value.
REQ-009 held_frames  output  8  frames since keycode_out last changed; saturates at 255.
REQ-010 The clock and reset SHALL be one clock, Clk, with reset asynchronous and active-low, Reset_n.

Function
REQ-011 Movement keys SHALL map to direction codes as follows: W=8'h1A=0, A=8'h04=1, S=8'h16=2, D=8'h07=3; all other keycodes SHALL be ignored.
REQ-012 On report_valid, pressed_mask[3:0] SHALL be set per direction if any slot equals that direction's keycode; duplicate slots SHALL count once.
REQ-013 A report where any slot equals 8'h01 (rollover error) SHALL be discarded entirely, with no state change.
REQ-014 The block SHALL hold a press-order stack: 4 entries of 2-bit direction codes plus a depth of 0..4; the top is the most recently pressed key.
REQ-015 Directions set in prev_mask and clear in pressed_mask SHALL be removed, and the entries above each removed entry SHALL compact down.
REQ-016 Directions set in pressed_mask and clear in prev_mask SHALL be pushed after removals, in ascending code order (W, A, S, D), so the highest new code ends on top.
REQ-017 Stack update and prev_mask <= pressed_mask SHALL complete on the edge ending the report_valid cycle (1-cycle latency).
REQ-018 Depth SHALL never exceed 4; a direction SHALL appear in the stack at most once.
REQ-019 On frame_tick, keycode_out SHALL load the top entry's keycode, or 8'h00 if depth=0.
REQ-020 When report_valid and frame_tick are asserted in the same cycle, frame_tick SHALL sample the pre-update stack, and the report SHALL apply on the same edge.
REQ-021 key_new SHALL pulse for the one cycle following a frame_tick edge that changes keycode_out; otherwise it SHALL be 0.
REQ-022 held_frames SHALL clear to 0 on a changing frame_tick, increment on a non-changing frame_tick, and hold at 255.
REQ-023 keycode_out SHALL change only on frame_tick edges; it SHALL be stable for the whole frame.

Reset
REQ-024 While Reset_n=0, the following SHALL hold: keycode_out=8'h00, key_new=0, held_frames=0, depth=0, prev_mask=4'b0000; stack entries are don't-care.
REQ-025 A reset asserted mid-frame SHALL take effect immediately, independent of Clk; the first report after release SHALL be treated as all-new presses.

Structure
REQ-026 key_pkg SHALL hold dir_t (2-bit enum W/A/S/D), the constants KC_W, KC_A, KC_S, KC_D, KC_NONE=8'h00 and KC_ROLLOVER=8'h01, and a dir-to-keycode function.
REQ-027 A single sub-module, key_stack, SHALL implement the ordered remove/compact/push with inputs remove_mask, push_mask and outputs top and depth.

Verification
REQ-028 The bench SHALL cover: report {04,00,00,00}, then frame_tick -> keycode_out=8'h04, key_new pulses once, held_frames=0.
REQ-029 The bench SHALL cover: hold A, then report {04,1A,00,00}, then frame_tick -> keycode_out=8'h1A; then report {04,00,00,00}, then frame_tick -> keycode_out=8'h04 (fallback).
REQ-030 The bench SHALL cover: report {1A,04,16,07} from empty -> depth=4, top=D, so keycode_out=8'h07; then release D -> keycode_out=8'h16.
REQ-031 The bench SHALL cover: report {01,01,01,01} while A is held -> stack unchanged, so keycode_out stays 8'h04.
REQ-032 The bench SHALL cover: report_valid and frame_tick in the same cycle (W pressed over empty) -> keycode_out=8'h00 that frame and 8'h1A at the next frame_tick.
REQ-033 The bench SHALL cover: 300 frame_ticks with A held -> held_frames=255, saturated; then Reset_n low mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and constants for the key direction filter.
//   dir_t      : 2-bit direction code, W=0, A=1, S=2, D=3
//   KC_*       : USB HID keycodes for the four movement keys, the empty slot
//                code and the rollover-error code
//   dir_to_kc  : maps a direction code back to its keycode
// -----------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    DIR_W = 2'd0,
    DIR_A = 2'd1,
    DIR_S = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  localparam logic [7:0] KC_W        = 8'h1A;
  localparam logic [7:0] KC_A        = 8'h04;
  localparam logic [7:0] KC_S        = 8'h16;
  localparam logic [7:0] KC_D        = 8'h07;
  localparam logic [7:0] KC_NONE     = 8'h00;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;

  localparam int         STACK_DEPTH = 4;
  localparam logic [7:0] HELD_MAX    = 8'd255;

  function automatic logic [7:0] dir_to_kc(input dir_t d);
    logic [7:0] kc;
    case (d)
      DIR_W:   kc = KC_W;
      DIR_A:   kc = KC_A;
      DIR_S:   kc = KC_S;
      default: kc = KC_D;
    endcase
    return kc;
  endfunction

endpackage

// File: rtl/key_direction_filter_if.sv
// -----------------------------------------------------------------------------
// key_direction_filter_if
// Bundles the report input, the frame strobe and the filtered outputs.
//
// Handshake: there is no backpressure. report_valid and frame_tick are
// single-cycle strobes that the filter always accepts on the rising edge
// that ends the cycle in which they are high; keycode_0..3 are only looked at
// while report_valid=1. key_new is a single-cycle strobe produced by the
// filter; keycode_out and held_frames are level outputs.
//
//   master : drives report_valid, keycode_0..3, frame_tick
//   slave  : drives keycode_out, key_new, held_frames and the dbg_* taps
//   dbg_depth / dbg_prev_mask expose the internal stack depth and the last
//   accepted pressed mask for observation.
// -----------------------------------------------------------------------------
interface key_direction_filter_if;
  logic       report_valid;
  logic [7:0] keycode_0;
  logic [7:0] keycode_1;
  logic [7:0] keycode_2;
  logic [7:0] keycode_3;
  logic       frame_tick;
  logic [7:0] keycode_out;
  logic       key_new;
  logic [7:0] held_frames;
  logic [2:0] dbg_depth;
  logic [3:0] dbg_prev_mask;

  modport master (
    output report_valid, keycode_0, keycode_1, keycode_2, keycode_3, frame_tick,
    input  keycode_out, key_new, held_frames, dbg_depth, dbg_prev_mask
  );

  modport slave (
    input  report_valid, keycode_0, keycode_1, keycode_2, keycode_3, frame_tick,
    output keycode_out, key_new, held_frames, dbg_depth, dbg_prev_mask
  );
endinterface

// File: rtl/key_stack.sv
// -----------------------------------------------------------------------------
// key_stack
// Press-order stack of up to four direction codes. On update, entries whose
// direction is in remove_mask are dropped and the survivors compact towards
// the bottom (keeping their relative order); then every direction in
// push_mask is pushed in ascending code order, so the highest new code ends
// on top.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   update       : apply remove_mask/push_mask on this edge
//   remove_mask  : one bit per direction to remove
//   push_mask    : one bit per direction to push
//   top          : most recently pushed direction (DIR_W when empty)
//   depth        : number of valid entries, 0..4
// -----------------------------------------------------------------------------
module key_stack
  import key_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       update,
  input  logic [3:0] remove_mask,
  input  logic [3:0] push_mask,
  output dir_t       top,
  output logic [2:0] depth
);

  dir_t       entry_q [STACK_DEPTH];
  dir_t       entry_d [STACK_DEPTH];
  logic [2:0] depth_q;
  logic [2:0] depth_d;

  // Scratch values for the compact/push walk.
  logic [2:0] fill;
  logic [3:0] kept_mask;
  logic [1:0] top_idx;

  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    depth_d   = depth_q;
    fill      = 3'd0;
    kept_mask = 4'b0000;

    if (update) begin
      // Walk bottom to top, copying survivors into the lowest free slot.
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (i < int'(depth_q) && !remove_mask[entry_q[i]]) begin
          entry_d[fill[1:0]]  = entry_q[i];
          kept_mask[entry_q[i]] = 1'b1;
          fill                = fill + 3'd1;
        end
      end
      // Ascending push order; skipping already-kept directions keeps every
      // direction unique even if the masks were inconsistent.
      for (int d = 0; d < STACK_DEPTH; d++) begin
        if (push_mask[d] && !kept_mask[d] && fill < 3'd4) begin
          entry_d[fill[1:0]] = dir_t'(d[1:0]);
          fill               = fill + 3'd1;
        end
      end
      depth_d = fill;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        entry_q[i] <= DIR_W;
      end
      depth_q <= 3'd0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      depth_q <= depth_d;
    end
  end

  // depth 4 wraps to index 3 through the 2-bit subtraction.
  assign top_idx = depth_q[1:0] - 2'd1;
  assign top     = (depth_q == 3'd0) ? DIR_W : entry_q[top_idx];
  assign depth   = depth_q;

endmodule

// File: rtl/key_direction_filter.sv
// -----------------------------------------------------------------------------
// key_direction_filter
// Turns raw 4-slot USB HID reports into a single movement keycode that the
// ball stage samples once per frame. The most recently pressed of W/A/S/D
// wins; releasing it falls back to the previously pressed key still held.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : report_valid + keycode_0..3 in, frame_tick in,
//                  keycode_out / key_new / held_frames out, debug taps
// -----------------------------------------------------------------------------
module key_direction_filter
  import key_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  key_direction_filter_if.slave bus
);

  logic [3:0] prev_mask_q, prev_mask_d;
  logic [7:0] keycode_out_q, keycode_out_d;
  logic       key_new_q, key_new_d;
  logic [7:0] held_frames_q, held_frames_d;

  logic       rollover;
  logic       accept;
  logic [3:0] pressed_mask;
  logic [3:0] remove_mask;
  logic [3:0] push_mask;
  logic [7:0] frame_kc;
  dir_t       stack_top;
  logic [2:0] stack_depth;

  function automatic logic slot_has(input logic [7:0] kc,
                                    input logic [7:0] k0, input logic [7:0] k1,
                                    input logic [7:0] k2, input logic [7:0] k3);
    return (k0 == kc) || (k1 == kc) || (k2 == kc) || (k3 == kc);
  endfunction

  // Report decode: duplicates collapse naturally because each direction bit
  // is an OR over all slots.
  always_comb begin
    rollover     = slot_has(KC_ROLLOVER, bus.keycode_0, bus.keycode_1,
                            bus.keycode_2, bus.keycode_3);
    pressed_mask = {slot_has(KC_D, bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3),
                    slot_has(KC_S, bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3),
                    slot_has(KC_A, bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3),
                    slot_has(KC_W, bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3)};
    // A rollover report carries no trustworthy key state, so it is dropped.
    accept       = bus.report_valid && !rollover;
    remove_mask  = prev_mask_q & ~pressed_mask;
    push_mask    = pressed_mask & ~prev_mask_q;
    prev_mask_d  = accept ? pressed_mask : prev_mask_q;
  end

  key_stack u_key_stack (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .update      (accept),
    .remove_mask (remove_mask),
    .push_mask   (push_mask),
    .top         (stack_top),
    .depth       (stack_depth)
  );

  // Frame sampling reads the registered stack, so a report arriving in the
  // same cycle only becomes visible at the following frame_tick.
  always_comb begin
    frame_kc      = (stack_depth == 3'd0) ? KC_NONE : dir_to_kc(stack_top);
    keycode_out_d = keycode_out_q;
    key_new_d     = 1'b0;
    held_frames_d = held_frames_q;
    if (bus.frame_tick) begin
      keycode_out_d = frame_kc;
      if (frame_kc != keycode_out_q) begin
        key_new_d     = 1'b1;
        held_frames_d = 8'd0;
      end else if (held_frames_q != HELD_MAX) begin
        held_frames_d = held_frames_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_mask_q   <= 4'b0000;
      keycode_out_q <= KC_NONE;
      key_new_q     <= 1'b0;
      held_frames_q <= 8'd0;
    end else begin
      prev_mask_q   <= prev_mask_d;
      keycode_out_q <= keycode_out_d;
      key_new_q     <= key_new_d;
      held_frames_q <= held_frames_d;
    end
  end

  assign bus.keycode_out   = keycode_out_q;
  assign bus.key_new       = key_new_q;
  assign bus.held_frames   = held_frames_q;
  assign bus.dbg_depth     = stack_depth;
  assign bus.dbg_prev_mask = prev_mask_q;

endmodule

// File: tb/tb_key_direction_filter.sv
// -----------------------------------------------------------------------------
// tb_key_direction_filter
// Directed scenarios followed by random reports/frame ticks. A queue-based
// reference model computes the expected frame output whenever a frame_tick is
// driven; a monitor compares it one cycle later.
// -----------------------------------------------------------------------------
module tb_key_direction_filter;

  logic clk;
  logic rst_n;

  key_direction_filter_if bus ();

  key_direction_filter dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         m_stk[$];       // press order, back = most recent
  bit [3:0]   m_prev;
  logic [7:0] m_kc;
  int         m_held;
  logic [16:0] exp_q[$];      // {keycode_out, key_new, held_frames}

  function automatic logic [7:0] kc_of(input int d);
    logic [7:0] t [4];
    t[0] = 8'h1A; t[1] = 8'h04; t[2] = 8'h16; t[3] = 8'h07;
    return t[d];
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_prev = 4'b0000;
    m_kc   = 8'h00;
    m_held = 0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    logic [7:0] nk;
    bit         nw;
    nk = (m_stk.size() == 0) ? 8'h00 : kc_of(m_stk[m_stk.size()-1]);
    if (nk != m_kc) begin
      m_kc = nk; m_held = 0; nw = 1'b1;
    end else begin
      nw = 1'b0;
      if (m_held < 255) m_held++;
    end
    exp_q.push_back({m_kc, nw, 8'(m_held)});
  endtask

  task automatic model_report(input logic [7:0] k [4]);
    bit [3:0] pressed;
    foreach (k[i]) if (k[i] == 8'h01) return;
    pressed = '0;
    for (int d = 0; d < 4; d++)
      foreach (k[i]) if (k[i] == kc_of(d)) pressed[d] = 1'b1;
    for (int i = m_stk.size() - 1; i >= 0; i--)
      if (!pressed[m_stk[i]]) m_stk.delete(i);
    for (int d = 0; d < 4; d++)
      if (pressed[d] && !m_prev[d]) m_stk.push_back(d);
    m_prev = pressed;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rv, input logic [7:0] k0, input logic [7:0] k1,
                       input logic [7:0] k2, input logic [7:0] k3, input bit ft);
    logic [7:0] k [4];
    @(negedge clk);
    bus.report_valid = rv;
    bus.keycode_0 = k0; bus.keycode_1 = k1; bus.keycode_2 = k2; bus.keycode_3 = k3;
    bus.frame_tick = ft;
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    if (ft) model_tick();          // tick sees the pre-report stack
    if (rv) model_report(k);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic report(input logic [7:0] k0, input logic [7:0] k1,
                        input logic [7:0] k2, input logic [7:0] k3);
    drive(1'b1, k0, k1, k2, k3, 1'b0);
  endtask

  task automatic tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic tick_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= bus.frame_tick;
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (tick_d) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL frame_out: output after frame_tick with no expectation at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_out", {15'd0, bus.keycode_out, bus.key_new, bus.held_frames}, {15'd0, e});
        end
      end else begin
        check("key_new_idle", {31'd0, bus.key_new}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pool [7];

  initial begin
    pool[0] = 8'h00; pool[1] = 8'h1A; pool[2] = 8'h04; pool[3] = 8'h16;
    pool[4] = 8'h07; pool[5] = 8'h05; pool[6] = 8'h01;
    bus.report_valid = 1'b0; bus.frame_tick = 1'b0;
    bus.keycode_0 = 8'h00; bus.keycode_1 = 8'h00; bus.keycode_2 = 8'h00; bus.keycode_3 = 8'h00;
    model_reset();
    rst_n = 1'b0;
    #23;
    check("rst_keycode_out", {24'd0, bus.keycode_out}, 32'h00);
    check("rst_key_new", {31'd0, bus.key_new}, 32'd0);
    check("rst_held", {24'd0, bus.held_frames}, 32'd0);
    check("rst_depth", {29'd0, bus.dbg_depth}, 32'd0);
    check("rst_prev_mask", {28'd0, bus.dbg_prev_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A pressed alone
    report(8'h04, 8'h00, 8'h00, 8'h00); idle(); tick(); idle();
    // W over A, then release W -> fallback to A
    report(8'h04, 8'h1A, 8'h00, 8'h00); tick(); idle();
    report(8'h04, 8'h00, 8'h00, 8'h00); tick(); idle();
    // rollover while A held: discarded
    report(8'h01, 8'h01, 8'h01, 8'h01); idle();
    check("rollover_prev_mask", {28'd0, bus.dbg_prev_mask}, 32'b0010);
    tick(); idle();
    // release all, then W with simultaneous tick
    report(8'h00, 8'h00, 8'h00, 8'h00); tick(); tick(); idle();
    drive(1'b1, 8'h1A, 8'h00, 8'h00, 8'h00, 1'b1); idle(); tick(); idle();
    // all four from empty, then release D
    report(8'h00, 8'h00, 8'h00, 8'h00); idle();
    report(8'h1A, 8'h04, 8'h16, 8'h07); idle();
    check("full_depth", {29'd0, bus.dbg_depth}, 32'd4);
    tick(); idle();
    report(8'h1A, 8'h04, 8'h16, 8'h00); tick(); idle();
    // duplicates count once
    report(8'h16, 8'h16, 8'h16, 8'h00); idle();
    check("dup_depth", {29'd0, bus.dbg_depth}, 32'd1);
    tick(); idle();

    // random phase
    for (int n = 0; n < 400; n++) begin
      bit rv, ft;
      rv = ($urandom_range(0, 2) == 0);
      ft = ($urandom_range(0, 3) == 0);
      drive(rv, pool[$urandom_range(0, 6) % ($urandom_range(0, 9) == 0 ? 7 : 6)],
            pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
            pool[$urandom_range(0, 5)], ft);
    end
    idle(); idle();

    // saturation with A held
    report(8'h04, 8'h00, 8'h00, 8'h00); idle();
    for (int n = 0; n < 300; n++) tick();
    idle(); idle();
    check("held_saturated", {24'd0, bus.held_frames}, 32'd255);
    check("held_keycode", {24'd0, bus.keycode_out}, 32'h04);

    // asynchronous reset mid-cycle
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_keycode_out", {24'd0, bus.keycode_out}, 32'h00);
    check("async_key_new", {31'd0, bus.key_new}, 32'd0);
    check("async_held", {24'd0, bus.held_frames}, 32'd0);
    check("async_depth", {29'd0, bus.dbg_depth}, 32'd0);
    check("async_prev_mask", {28'd0, bus.dbg_prev_mask}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // first report after release is all-new
    report(8'h04, 8'h00, 8'h00, 8'h00); tick(); idle(); idle();

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expected outputs never observed", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
